// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command path: opcodes, HD44780 instruction codes,
// FSM state types and small decode helpers.
package lcd_pkg;

    localparam logic [3:0] OP_CLEAR = 4'd0;
    localparam logic [3:0] OP_WRITE = 4'd1;
    localparam logic [3:0] OP_SETCG = 4'd2;
    localparam logic [3:0] OP_SETAD = 4'd3;
    localparam logic [3:0] OP_WAIT2 = 4'd4;
    localparam logic [3:0] OP_WAIT1 = 4'd15;

    localparam logic [7:0] HD_FUNC_SET  = 8'h38;
    localparam logic [7:0] HD_DISP_ON   = 8'h0C;
    localparam logic [7:0] HD_CLEAR     = 8'h01;
    localparam logic [7:0] HD_ENTRY     = 8'h06;
    localparam logic [7:0] HD_SET_CGRAM = 8'h40;
    localparam logic [7:0] HD_SET_DDRAM = 8'h80;

    localparam logic [7:0] LINE2_BASE = 8'd40;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT_BUS,
        ST_INIT_WAIT,
        ST_RDY_HI,
        ST_LATCH,
        ST_BUS,
        ST_EXEC_WAIT
    } lcd_state_t;

    typedef enum logic [1:0] {
        SP_IDLE,
        SP_SETUP,
        SP_EN_HI,
        SP_HOLD
    } strobe_phase_t;

    function automatic logic [7:0] init_word(input logic [1:0] step);
        case (step)
            2'd0:    return HD_FUNC_SET;
            2'd1:    return HD_DISP_ON;
            2'd2:    return HD_CLEAR;
            default: return HD_ENTRY;
        endcase
    endfunction

    function automatic logic is_bus_op(input logic [3:0] op);
        return (op <= OP_SETAD);
    endfunction

    function automatic logic cmd_rs(input logic [3:0] op);
        return (op == OP_WRITE);
    endfunction

    // Positions 40..79 fold onto line 2, which starts at DDRAM 0x40.
    function automatic logic [7:0] cmd_db(input logic [3:0] op, input logic [7:0] arg);
        logic [7:0] pos;
        pos = (arg < LINE2_BASE) ? arg : (arg - LINE2_BASE + 8'h40);
        case (op)
            OP_CLEAR: return HD_CLEAR;
            OP_WRITE: return arg;
            OP_SETCG: return HD_SET_CGRAM | {2'b00, arg[5:0]};
            OP_SETAD: return HD_SET_DDRAM | {1'b0, pos[6:0]};
            default:  return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/lcd_hd44780_driver_if.sv
// Command handshake between the LCD command generator (master) and the driver (slave).
interface lcd_hd44780_driver_if;
    logic [11:0] cmd;
    logic        rdy;
    logic        busy;

    modport master (output cmd, input rdy, input busy);
    modport slave  (input cmd, output rdy, output busy);
endinterface

// File: rtl/lcd_bus_strobe.sv
// One HD44780 write bus cycle: RS/DB setup, EN high, RS/DB hold. RS/DB are
// captured on start and kept afterwards, so idle commands leave the bus untouched.
module lcd_bus_strobe #(
    parameter int T_SETUP = 4,
    parameter int T_EN    = 13,
    parameter int T_HOLD  = 4,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] db,
    output logic       done,
    output logic       lcd_rs,
    output logic [7:0] lcd_db,
    output logic       lcd_en
);
    import lcd_pkg::*;

    strobe_phase_t    phase_r;
    strobe_phase_t    phase_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] load_s;

    function automatic logic [CNT_W-1:0] dly(input int t);
        if (t <= 32'sd1) return '0;
        else             return CNT_W'(t - 32'sd1);
    endfunction

    // phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_r <= SP_IDLE;
        else        phase_r <= phase_next_s;
    end

    // next-phase decode
    always_comb begin
        phase_next_s = phase_r;
        case (phase_r)
            SP_IDLE:  if (start) phase_next_s = SP_SETUP;   else phase_next_s = SP_IDLE;
            SP_SETUP: if (cnt_r == '0) phase_next_s = SP_EN_HI; else phase_next_s = SP_SETUP;
            SP_EN_HI: if (cnt_r == '0) phase_next_s = SP_HOLD;  else phase_next_s = SP_EN_HI;
            SP_HOLD:  if (cnt_r == '0) phase_next_s = SP_IDLE;  else phase_next_s = SP_HOLD;
            default:  phase_next_s = SP_IDLE;
        endcase
    end

    // counter reload value and completion flag
    always_comb begin
        load_s = '0;
        case (phase_next_s)
            SP_SETUP: load_s = dly(T_SETUP);
            SP_EN_HI: load_s = dly(T_EN);
            SP_HOLD:  load_s = dly(T_HOLD);
            default:  load_s = '0;
        endcase
        done = (phase_r == SP_HOLD) && (cnt_r == '0);
    end

    // phase counter and registered bus pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            lcd_en <= 1'b0;
            lcd_rs <= 1'b0;
            lcd_db <= 8'h00;
        end else begin
            if (phase_next_s != phase_r) cnt_r <= load_s;
            else if (cnt_r != '0)        cnt_r <= cnt_r - CNT_W'(1);
            else                         cnt_r <= cnt_r;
            lcd_en <= (phase_next_s == SP_EN_HI);
            if ((phase_r == SP_IDLE) && start) begin
                lcd_rs <= rs;
                lcd_db <= db;
            end else begin
                lcd_rs <= lcd_rs;
                lcd_db <= lcd_db;
            end
        end
    end

endmodule

// File: rtl/lcd_hd44780_driver.sv
// HD44780 character LCD driver: runs panel power-up init, then executes one
// generator command per rdy rising edge with correct bus and execution timing.
module lcd_hd44780_driver #(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 4,
    parameter int T_EN    = 13,
    parameter int T_HOLD  = 4,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000,
    parameter int T_RDY   = 8,
    parameter int T_IDLE  = 2000,
    parameter int CNT_W   = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lcd_hd44780_driver_if.slave   bus,
    output logic [7:0]            LCD_DATA,
    output logic                  LCD_RS,
    output logic                  LCD_RW,
    output logic                  LCD_EN,
    output logic                  LCD_ON,
    output logic                  LCD_BLON
);
    import lcd_pkg::*;

    lcd_state_t       state_r;
    lcd_state_t       state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] load_s;
    logic [1:0]       step_r;
    logic [3:0]       op_r;
    logic             rdy_r;
    logic             busy_r;
    logic             strobe_start_s;
    logic             strobe_rs_s;
    logic [7:0]       strobe_db_s;
    logic             strobe_done_s;

    function automatic logic [CNT_W-1:0] dly(input int t);
        if (t <= 32'sd1) return '0;
        else             return CNT_W'(t - 32'sd1);
    endfunction

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_PWR_WAIT;
        else        state_r <= state_next_s;
    end

    // next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_PWR_WAIT:  if (cnt_r == dly(T_PWRUP)) state_next_s = ST_INIT_BUS; else state_next_s = ST_PWR_WAIT;
            ST_INIT_BUS:  if (strobe_done_s) state_next_s = ST_INIT_WAIT; else state_next_s = ST_INIT_BUS;
            ST_INIT_WAIT: begin
                if (cnt_r == '0) state_next_s = (step_r == 2'd3) ? ST_RDY_HI : ST_INIT_BUS;
                else             state_next_s = ST_INIT_WAIT;
            end
            ST_RDY_HI:    if (cnt_r == '0) state_next_s = ST_LATCH; else state_next_s = ST_RDY_HI;
            ST_LATCH:     state_next_s = is_bus_op(bus.cmd[11:8]) ? ST_BUS : ST_EXEC_WAIT;
            ST_BUS:       if (strobe_done_s) state_next_s = ST_EXEC_WAIT; else state_next_s = ST_BUS;
            ST_EXEC_WAIT: if (cnt_r == '0) state_next_s = ST_RDY_HI; else state_next_s = ST_EXEC_WAIT;
            default:      state_next_s = ST_PWR_WAIT;
        endcase
    end

    // outputs: strobe launch with its RS/DB, and delay reload for the next state
    always_comb begin
        strobe_start_s = 1'b0;
        strobe_rs_s    = 1'b0;
        strobe_db_s    = 8'h00;
        load_s         = '0;
        case (state_r)
            ST_PWR_WAIT: begin
                if (state_next_s == ST_INIT_BUS) begin
                    strobe_start_s = 1'b1;
                    strobe_db_s    = init_word(2'd0);
                end else begin
                    strobe_start_s = 1'b0;
                end
            end
            ST_INIT_WAIT: begin
                if (state_next_s == ST_INIT_BUS) begin
                    strobe_start_s = 1'b1;
                    strobe_db_s    = init_word(step_r + 2'd1);
                end else begin
                    strobe_start_s = 1'b0;
                end
            end
            ST_LATCH: begin
                if (state_next_s == ST_BUS) begin
                    strobe_start_s = 1'b1;
                    strobe_rs_s    = cmd_rs(bus.cmd[11:8]);
                    strobe_db_s    = cmd_db(bus.cmd[11:8], bus.cmd[7:0]);
                end else begin
                    strobe_start_s = 1'b0;
                end
            end
            default: strobe_start_s = 1'b0;
        endcase
        case (state_next_s)
            ST_INIT_WAIT: load_s = (step_r == 2'd2) ? dly(T_CLR) : dly(T_CMD);
            ST_RDY_HI:    load_s = dly(T_RDY);
            ST_EXEC_WAIT: begin
                if (state_r == ST_LATCH)     load_s = dly(T_IDLE);
                else if (op_r == OP_CLEAR)   load_s = dly(T_CLR);
                else                         load_s = dly(T_CMD);
            end
            default:      load_s = '0;
        endcase
    end

    // Power-up wait counts up from the reset value 0; every other state reloads and counts down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            step_r <= 2'd0;
            op_r   <= 4'd0;
            rdy_r  <= 1'b0;
            busy_r <= 1'b1;
        end else begin
            if (state_next_s != state_r)     cnt_r <= load_s;
            else if (state_r == ST_PWR_WAIT) cnt_r <= cnt_r + CNT_W'(1);
            else if (cnt_r != '0)            cnt_r <= cnt_r - CNT_W'(1);
            else                             cnt_r <= cnt_r;

            if (state_r == ST_PWR_WAIT)                                      step_r <= 2'd0;
            else if ((state_r == ST_INIT_WAIT) && (state_next_s == ST_INIT_BUS)) step_r <= step_r + 2'd1;
            else                                                             step_r <= step_r;

            if (state_r == ST_LATCH) op_r <= bus.cmd[11:8];
            else                     op_r <= op_r;

            rdy_r  <= (state_next_s == ST_RDY_HI);
            busy_r <= (state_next_s != ST_RDY_HI);
        end
    end

    lcd_bus_strobe #(
        .T_SETUP (T_SETUP),
        .T_EN    (T_EN),
        .T_HOLD  (T_HOLD),
        .CNT_W   (CNT_W)
    ) u_strobe (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (strobe_start_s),
        .rs     (strobe_rs_s),
        .db     (strobe_db_s),
        .done   (strobe_done_s),
        .lcd_rs (LCD_RS),
        .lcd_db (LCD_DATA),
        .lcd_en (LCD_EN)
    );

    assign bus.rdy  = rdy_r;
    assign bus.busy = busy_r;
    assign LCD_RW   = 1'b0;
    assign LCD_ON   = 1'b1;
    assign LCD_BLON = 1'b1;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Directed testbench for lcd_hd44780_driver with shortened power-up and wait times.
module tb_lcd_hd44780_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;

    lcd_hd44780_driver_if bus();

    lcd_hd44780_driver #(
        .T_PWRUP(20), .T_SETUP(4), .T_EN(13), .T_HOLD(4),
        .T_CMD(10), .T_CLR(30), .T_RDY(8), .T_IDLE(5), .CNT_W(20)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .LCD_DATA (lcd_data),
        .LCD_RS   (lcd_rs),
        .LCD_RW   (lcd_rw),
        .LCD_EN   (lcd_en),
        .LCD_ON   (lcd_on),
        .LCD_BLON (lcd_blon)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // bus monitor: EN pulses (cycle, DB, RS, width) and rdy rising edges
    int         en_rise[$];
    logic [7:0] en_db[$];
    logic       en_rsq[$];
    int         en_len[$];
    int         rdy_rise[$];
    logic       en_q = 1'b0;
    logic       rdy_q = 1'b0;
    int         last_rise = 0;

    always @(negedge clk) begin
        if (lcd_en && !en_q) begin
            en_rise.push_back(cyc);
            en_db.push_back(lcd_data);
            en_rsq.push_back(lcd_rs);
            last_rise <= cyc;
        end
        if (!lcd_en && en_q) en_len.push_back(cyc - last_rise);
        if (bus.rdy && !rdy_q) rdy_rise.push_back(cyc);
        en_q  <= lcd_en;
        rdy_q <= bus.rdy;
    end

    int checks = 0;
    int errors = 0;
    int rdy_idx = 0;
    int prev_rdy = 0;

    task automatic wait_rdy(output int at);
        int n = 0;
        while (rdy_rise.size() <= rdy_idx && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (rdy_rise.size() <= rdy_idx) begin
            errors++;
            $display("FAIL rdy_timeout: got no rdy rise #%0d within %0d cycles, expected one", rdy_idx, n);
            at = -1;
        end else begin
            at = rdy_rise[rdy_idx];
            rdy_idx++;
        end
    endtask

    task automatic wait_en_high();
        int n = 0;
        while (!lcd_en && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (!lcd_en) begin
            errors++;
            $display("FAIL en_timeout: EN=%0b after %0d cycles, expected 1", lcd_en, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd = 12'h000;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.rdy !== 1'b0)  begin errors++; $display("FAIL reset_rdy: got %b expected 0", bus.rdy); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", bus.busy); end
        checks++; if (lcd_en !== 1'b0)   begin errors++; $display("FAIL reset_en: got %b expected 0", lcd_en); end
        checks++; if ({lcd_rs, lcd_data} !== 9'h000) begin errors++; $display("FAIL reset_rs_db: got %h expected 000", {lcd_rs, lcd_data}); end
        checks++; if ({lcd_rw, lcd_on, lcd_blon} !== 3'b011) begin errors++; $display("FAIL reset_rw_on_blon: got %b expected 011", {lcd_rw, lcd_on, lcd_blon}); end
    endtask

    task automatic test_init();
        logic [7:0] exp_db [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
        int rel, base, r0;
        rst_n = 1'b1;
        rel  = cyc;
        base = en_rise.size();
        wait_rdy(r0);
        // 20 power-up + 3 x (21 bus + 10) + (21 bus + 30 clear wait)
        checks++; if (r0 - rel !== 164) begin errors++; $display("FAIL init_rdy_time: got %0d expected 164", r0 - rel); end
        checks++;
        if (en_rise.size() - base !== 4) begin
            errors++; $display("FAIL init_pulse_count: got %0d expected 4", en_rise.size() - base);
        end else begin
            checks++; if (en_rise[base] - rel < 21) begin errors++; $display("FAIL init_pwrup: EN at %0d expected >= 21", en_rise[base] - rel); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({en_rsq[base+i], en_db[base+i]} !== {1'b0, exp_db[i]}) begin
                    errors++; $display("FAIL init_word%0d: got rs=%b db=%h expected rs=0 db=%h", i, en_rsq[base+i], en_db[base+i], exp_db[i]);
                end
            end
            checks++;
            if (en_rise[base+3] - (en_rise[base+2] + en_len[base+2]) < 30) begin
                errors++; $display("FAIL init_clear_gap: got %0d expected >= 30", en_rise[base+3] - (en_rise[base+2] + en_len[base+2]));
            end
        end
        prev_rdy = r0;
    endtask

    task automatic test_commands();
        logic [11:0] cmds [6] = '{12'h328, 12'h330, 12'h304, 12'h2FF, 12'h000, 12'h141};
        logic [7:0]  dbs  [6] = '{8'hC0, 8'hC8, 8'h84, 8'h7F, 8'h01, 8'h41};
        logic        rss  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          gaps [6] = '{40, 40, 40, 40, 60, 40};
        int nb, r;
        for (int i = 0; i < 6; i++) begin
            bus.cmd = cmds[i];
            nb = en_rise.size();
            wait_rdy(r);
            checks++; if (r - prev_rdy !== gaps[i]) begin errors++; $display("FAIL cmd_%h_latency: got %0d expected %0d", cmds[i], r - prev_rdy, gaps[i]); end
            checks++;
            if (en_rise.size() !== nb + 1) begin
                errors++; $display("FAIL cmd_%h_pulses: got %0d expected 1", cmds[i], en_rise.size() - nb);
            end else begin
                checks++;
                if ({en_rsq[nb], en_db[nb], en_len[nb]} !== {rss[i], dbs[i], 32'd13}) begin
                    errors++; $display("FAIL cmd_%h_bus: got rs=%b db=%h en_len=%0d expected rs=%b db=%h en_len=13",
                                       cmds[i], en_rsq[nb], en_db[nb], en_len[nb], rss[i], dbs[i]);
                end
            end
            prev_rdy = r;
        end
    endtask

    task automatic test_nobus();
        logic [11:0] cmds [2] = '{12'hF00, 12'h4AA};
        int nb, r;
        for (int i = 0; i < 2; i++) begin
            bus.cmd = cmds[i];
            nb = en_rise.size();
            wait_rdy(r);
            checks++; if (r - prev_rdy !== 14) begin errors++; $display("FAIL idle_%h_latency: got %0d expected 14", cmds[i], r - prev_rdy); end
            checks++; if (en_rise.size() !== nb) begin errors++; $display("FAIL idle_%h_pulses: got %0d expected 0", cmds[i], en_rise.size() - nb); end
            checks++; if ({lcd_rs, lcd_data} !== 9'h141) begin errors++; $display("FAIL idle_%h_bus_kept: got %h expected 141", cmds[i], {lcd_rs, lcd_data}); end
            prev_rdy = r;
        end
    endtask

    task automatic test_cmd_toggle();
        int r;
        bus.cmd = 12'h155;
        wait_en_high();
        bus.cmd = 12'h1AA;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (lcd_data !== 8'h55) begin errors++; $display("FAIL toggle_during_en: got %h expected 55", lcd_data); end
        wait_rdy(r);
        checks++; if (lcd_data !== 8'h55) begin errors++; $display("FAIL toggle_before_latch: got %h expected 55", lcd_data); end
        checks++; if (r - prev_rdy !== 40) begin errors++; $display("FAIL toggle_latency: got %0d expected 40", r - prev_rdy); end
        prev_rdy = r;
        wait_rdy(r);
        checks++; if (en_db[en_db.size()-1] !== 8'hAA) begin errors++; $display("FAIL toggle_next_latch: got %h expected AA", en_db[en_db.size()-1]); end
        prev_rdy = r;
    endtask

    task automatic test_reset_mid();
        int rel, base, r;
        bus.cmd = 12'h141;
        wait_en_high();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if ({lcd_en, bus.rdy, lcd_rs} !== 3'b000) begin errors++; $display("FAIL midreset_async: got en,rdy,rs=%b expected 000", {lcd_en, bus.rdy, lcd_rs}); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midreset_busy: got %b expected 1", bus.busy); end
        @(negedge clk);
        #1;
        rst_n   = 1'b1;
        rel     = cyc;
        base    = en_rise.size();
        rdy_idx = rdy_rise.size();
        wait_rdy(r);
        checks++; if (r - rel !== 164) begin errors++; $display("FAIL midreset_rdy_time: got %0d expected 164", r - rel); end
        checks++;
        if (en_rise.size() - base !== 4) begin
            errors++; $display("FAIL midreset_pulse_count: got %0d expected 4", en_rise.size() - base);
        end else begin
            checks++;
            if ({en_rsq[base], en_db[base], en_rsq[base+3], en_db[base+3]} !== {1'b0, 8'h38, 1'b0, 8'h06}) begin
                errors++; $display("FAIL midreset_init_words: got %h/%h expected 38/06", en_db[base], en_db[base+3]);
            end
            checks++; if (en_rise[base] - rel < 21) begin errors++; $display("FAIL midreset_pwrup: EN at %0d expected >= 21", en_rise[base] - rel); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_commands();
        test_nobus();
        test_cmd_toggle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
